// File: rtl/rr_ring_arbiter.sv
// Four-requester round-robin arbiter with a rotating one-hot priority pointer.
// An owner holds its grant for at most QUANTUM cycles before losing it.
module rr_ring_arbiter #(
  parameter int QUANTUM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [3:0] ptr,
  output logic       busy,
  output logic       expire
);

  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [3:0] nptr;
  logic [3:0] cand;
  logic [3:0] sel_idle;
  logic [3:0] sel_rel;
  logic       vol;
  logic       xp;
  logic       rel;

  // First set bit of r, scanning upward from the one-hot position p.
  function automatic logic [3:0] pick(
    input logic [3:0] p,
    input logic [3:0] r
  );
    logic [3:0] c;
    logic [3:0] g;
    c = p;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      if (g == '0 && (c & r) != '0)
        g = c;
      c = {c[2:0], c[3]};
    end
    return g;
  endfunction

  // Release detection and candidate selection for the next edge.
  always_comb begin
    nptr     = {grant[2:0], grant[3]};
    vol      = (req & grant) == '0;
    xp       = !vol && (cnt == LAST);
    rel      = vol || xp;
    // The owner never competes at its own release edge.
    cand     = req & ~grant;
    sel_idle = pick(ptr, req);
    sel_rel  = pick(nptr, cand);
  end

  // Arbitration FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= 4'b0000;
      ptr    <= 4'b0001;
      cnt    <= '0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req != '0) begin
            grant <= sel_idle;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          if (rel) begin
            ptr    <= nptr;
            expire <= xp;
            cnt    <= '0;
            if (cand != '0) begin
              grant <= sel_rel;
            end else begin
              grant <= 4'b0000;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_ring_arbiter.md
RR_RING_ARBITER -- requirements
Module: rr_ring_arbiter

Interface
REQ-001 Parameter QUANTUM, default 4, maximum consecutive grant cycles per requester; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 grant  output  4  registered one-hot grant, or 4'b0000 when idle.
REQ-006 ptr  output  4  registered one-hot ring priority pointer; bit set = highest-priority requester.
REQ-007 busy  output  1  registered; 1 whenever grant != 4'b0000.
REQ-008 expire  output  1  registered one-cycle pulse; 1 in the cycle after a grant is revoked by quantum expiry.

Function
REQ-009 The block SHALL implement two states: IDLE (grant == 0) and OWN (exactly one grant bit set).
REQ-010 ptr SHALL always be one-hot; ring rotation SHALL be bit i -> bit i+1, bit 3 -> bit 0.
REQ-011 Selection SHALL pick the first set req bit scanning circularly from the ptr position upward (ptr bit, ptr+1, ... wrapping 3 -> 0).
REQ-012 In IDLE with req != 0 at an edge, grant SHALL become the selected one-hot value at that edge (1-cycle latency), state -> OWN, hold counter cnt cleared to 0.
REQ-013 In IDLE with req == 0, grant, ptr and cnt SHALL hold; state stays IDLE.
REQ-014 In OWN, cnt SHALL increment by 1 each edge the grant is held; cnt width = clog2(QUANTUM), no wrap reachable.
REQ-015 Release SHALL occur at an edge where the granted req bit is 0 (voluntary) or cnt == QUANTUM-1 (expiry); grant visible at most QUANTUM cycles.
REQ-016 On release, ptr SHALL load the current grant rotated by one position (requester after the owner becomes highest priority).
REQ-017 On release, selection SHALL be recomputed with the updated ptr and the current req, excluding the releasing requester on expiry; if a candidate exists, grant moves to it at the same edge (back-to-back, no idle cycle), cnt -> 0, state stays OWN.
REQ-018 On release with no candidate, grant SHALL become 0 and state -> IDLE.
REQ-019 On voluntary release, the releasing requester is a candidate only if its req bit is set (it cannot be, per REQ-015), so it SHALL not be re-granted at that edge.
REQ-020 On expiry with only the owner requesting, grant SHALL drop to 0 for exactly one cycle, then re-grant the owner at the next edge via REQ-012.
REQ-021 expire SHALL be 1 for the single cycle following an expiry release, 0 otherwise; voluntary release never asserts it.
REQ-022 Changes to non-granted req bits during OWN SHALL not affect grant until release.
REQ-023 busy SHALL equal (grant != 0) at all times, registered alongside grant.

Reset
REQ-024 With reset = 1 at an edge: state -> IDLE, grant = 4'b0000, ptr = 4'b0001, cnt = 0, busy = 0, expire = 0.
REQ-025 Reset SHALL take priority over all other activity, including mid-grant; a grant in progress is dropped at that edge and no expire pulse follows.
REQ-026 First edge with reset = 0 SHALL behave as IDLE per REQ-012/013.

Verification
REQ-027 Reset then req=4'b0100 -> one edge later grant=0100, busy=1; drop req -> next edge grant=0000, ptr=1000, expire=0.
REQ-028 QUANTUM=4, req=4'b1111 held constant from ptr=0001 -> grants 0001,0010,0100,1000,0001 each exactly 4 cycles, back-to-back, expire pulsing after each handover, ptr rotating 0010,0100,1000,0001.
REQ-029 QUANTUM=4, only req[2] held high -> grant=0100 for 4 cycles, 0000 for 1 cycle with expire=1, then 0100 again.
REQ-030 Grant to 0001, req[1] and req[3] raised while req[0] held 2 cycles then dropped -> grant moves to 0010 at the drop edge, ptr=0010, then 1000 after req[1] drops.
REQ-031 Reset asserted while grant=1000 with cnt=2 -> next edge grant=0000, ptr=0001, busy=0, expire=0; after reset with req=4'b1001 -> grant=0001.
REQ-032 Wrap-around: ptr=1000, req=4'b0011 in IDLE -> grant=0001 (scan 3 -> 0), not 0010.
